blackjack_bet_ledger: RTL and testbench
=======================================

// Module: blackjack_bet_ledger
// PURPOSE
//  Bet/settlement controller sitting directly upstream of blackjack_game_ram; sole driver of its addr/write_data/write_en.
//  Accepts PLACE / SETTLE / NEW_ROUND commands from the game FSM and runs read-modify-write sequences on
//  balance (addr 0), current bet (addr 1), player/dealer card counts (addr 2/3). One command in flight.
// PARAMETERS
//  CURRENCY_BITS  16   width of balance, bet and RAM data
//  MAX_BET        500  largest legal PLACE amount
// PORTS
//  clk             in   1    clock
//  rst             in   1    reset, synchronous, active-high (shared with blackjack_game_ram)
//  cmd_valid       in   1    command request
//  cmd_ready       out  1    high only in IDLE; cmd accepted on cmd_valid&&cmd_ready
//  cmd_op          in   2    0 PLACE, 1 SETTLE, 2 NEW_ROUND, 3 illegal
//  cmd_bet         in   CB   bet amount (PLACE only)
//  cmd_outcome     in   2    0 LOSE, 1 PUSH, 2 WIN, 3 BLACKJACK (SETTLE only)
//  ram_addr        out  4    to RAM addr
//  ram_write_data  out  CB   to RAM write_data
//  ram_write_en    out  1    to RAM write_en
//  ram_read_data   in   CB   from RAM read_data (registered, 1-cycle latency)
//  done            out  1    1-cycle pulse, command complete
//  error           out  1    valid with done; 1 = rejected, RAM unmodified
//  balance_out     out  CB   last balance read or written
// BEHAVIOUR
//  Reset: state IDLE; done=0, error=0, balance_out=0, ram_addr=0, ram_write_en=0, ram_write_data=0.
//  cmd_op/cmd_bet/cmd_outcome latched at accept edge; inputs ignored while busy (cmd_ready=0).
//  ram_* are Moore outputs decoded from state + latched regs; ram_write_en=0 in all states except writes.
//  PLACE/SETTLE path (cycle n = n clocks after accept edge):
//   RD_BET  n1: addr=1
//   RD_BAL  n2: addr=0; ram_read_data holds bet -> latch bet_q at end of cycle
//   CALC    n3: addr=0; ram_read_data holds balance -> latch bal_q; evaluate legality
//   WR_BAL  n4: addr=0, we=1, data=new_bal; balance_out<=new_bal
//   WR_BET  n5: addr=1, we=1, data=new_bet
//   DONE    n6: done=1, error=0 -> IDLE
//   Illegal at CALC -> DONE at n4 with error=1, balance_out<=bal_q, no writes.
//  PLACE legal iff cmd_bet!=0, cmd_bet<=MAX_BET, cmd_bet<=bal_q, bet_q==0.
//   new_bal=bal_q-cmd_bet; new_bet=cmd_bet.
//  SETTLE legal iff bet_q!=0. credit: LOSE 0; PUSH bet_q; WIN 2*bet_q;
//   BLACKJACK 2*bet_q+(bet_q>>1) (3:2, floored). Sum computed in CB+2 bits;
//   new_bal=min(bal_q+credit, 2^CB-1) (saturate, never wrap); new_bet=0.
//  NEW_ROUND: CLR_P n1 (addr=2,we=1,data=0), CLR_D n2 (addr=3,we=1,data=0), DONE n3 error=0.
//   Balance/bet untouched.
//  op 3: DONE at n1 with error=1, no RAM access.
//  done/error high exactly one cycle; cmd_ready rises the cycle after DONE (IDLE); back-to-back
//   command accepted in that IDLE cycle.
//  Reset mid-command: abandon immediately, all outputs to reset values next cycle; RAM resets
//   in same cycle, so partial writes are discarded by RAM reset.
// TESTING
//  (bench instantiates blackjack_game_ram with a backdoor write mux for preloads)
//  T1 reset, PLACE bet=100 -> done at n6, error=0, RAM[0]=900, RAM[1]=100, balance_out=900.
//  T2 RAM bal=899 bet=101, SETTLE BLACKJACK -> RAM[0]=1151, RAM[1]=0, done n6.
//  T3 bal=1000 PLACE 1001; PLACE 0; PLACE 501 -> each error=1 at n4, write_en never high, RAM unchanged.
//  T4 SETTLE with bet=0 -> error; PLACE 50 with bet=100 outstanding -> error; op 3 -> error at n1.
//  T5 bal=65000 bet=1000 SETTLE WIN -> RAM[0]=65535 (saturated); LOSE -> bal unchanged, bet=0.
//  T6 NEW_ROUND with counts 3/4 -> RAM[2]=RAM[3]=0, done n3; cmd_valid held while busy not accepted;
//     rst asserted during WR_BET -> IDLE, done=0, RAM[0]=1000 next cycle.

Source files
------------

// File: rtl/blackjack_bet_ledger.sv
// Bet/settlement sequencer for blackjack_game_ram: runs read-modify-write passes over
// balance (0), bet (1) and the card counts (2/3), one command at a time.
module blackjack_bet_ledger #(
  parameter int CURRENCY_BITS = 16,
  parameter int MAX_BET       = 500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CURRENCY_BITS-1:0] cmd_bet,
  input  logic [1:0]               cmd_outcome,
  output logic [3:0]               ram_addr,
  output logic [CURRENCY_BITS-1:0] ram_write_data,
  output logic                     ram_write_en,
  input  logic [CURRENCY_BITS-1:0] ram_read_data,
  output logic                     done,
  output logic                     error,
  output logic [CURRENCY_BITS-1:0] balance_out
);
  localparam int CB = CURRENCY_BITS;
  localparam logic [CB-1:0] MAX_BET_C = CB'(MAX_BET);

  localparam logic [1:0] OP_PLACE  = 2'd0;
  localparam logic [1:0] OP_SETTLE = 2'd1;
  localparam logic [1:0] OP_NEWRND = 2'd2;

  localparam logic [1:0] OC_LOSE = 2'd0;
  localparam logic [1:0] OC_PUSH = 2'd1;
  localparam logic [1:0] OC_WIN  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_BET, S_RD_BAL, S_CALC, S_WR_BAL, S_WR_BET, S_CLR_P, S_CLR_D, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [CB-1:0] bet;
    logic [1:0]    outcome;
  } cmd_t;

  state_t        state, next_state;
  cmd_t          cmd_q;
  logic [CB-1:0] bet_q;
  logic [CB-1:0] new_bal_q;
  logic          err_q;

  // Settlement math: widest credit is 2.5x bet plus balance, so CB+2 bits never overflow.
  logic [CB+1:0] bet_x, credit, sum;
  logic [CB-1:0] settle_bal;
  logic          place_ok, settle_ok, legal;

  always_comb begin
    bet_x = {2'b00, bet_q};
    case (cmd_q.outcome)
      OC_LOSE: credit = '0;
      OC_PUSH: credit = bet_x;
      OC_WIN:  credit = bet_x << 1;
      default: credit = (bet_x << 1) + (bet_x >> 1);
    endcase
    sum        = {2'b00, ram_read_data} + credit;
    settle_bal = (sum[CB+1:CB] != 2'b00) ? '1 : sum[CB-1:0];
    place_ok   = (cmd_q.bet != '0) && (cmd_q.bet <= MAX_BET_C) &&
                 (cmd_q.bet <= ram_read_data) && (bet_q == '0);
    settle_ok  = (bet_q != '0);
    legal      = (cmd_q.op == OP_PLACE) ? place_ok : settle_ok;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:
        if (cmd_valid) begin
          case (cmd_op)
            OP_PLACE, OP_SETTLE: next_state = S_RD_BET;
            OP_NEWRND:           next_state = S_CLR_P;
            default:             next_state = S_DONE;
          endcase
        end
      S_RD_BET: next_state = S_RD_BAL;
      S_RD_BAL: next_state = S_CALC;
      S_CALC:   next_state = legal ? S_WR_BAL : S_DONE;
      S_WR_BAL: next_state = S_WR_BET;
      S_WR_BET: next_state = S_DONE;
      S_CLR_P:  next_state = S_CLR_D;
      S_CLR_D:  next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // RAM port is a pure decode of state so nothing glitches onto write_en between passes.
  always_comb begin
    ram_addr       = 4'd0;
    ram_write_en   = 1'b0;
    ram_write_data = '0;
    case (state)
      S_RD_BET: ram_addr = 4'd1;
      S_WR_BAL: begin
        ram_write_en   = 1'b1;
        ram_write_data = new_bal_q;
      end
      S_WR_BET: begin
        ram_addr       = 4'd1;
        ram_write_en   = 1'b1;
        ram_write_data = (cmd_q.op == OP_PLACE) ? cmd_q.bet : '0;
      end
      S_CLR_P: begin
        ram_addr     = 4'd2;
        ram_write_en = 1'b1;
      end
      S_CLR_D: begin
        ram_addr     = 4'd3;
        ram_write_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign error     = done & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      bet_q       <= '0;
      new_bal_q   <= '0;
      err_q       <= 1'b0;
      balance_out <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            cmd_q <= '{op: cmd_op, bet: cmd_bet, outcome: cmd_outcome};
            err_q <= (cmd_op == 2'd3);
          end
        S_RD_BAL: bet_q <= ram_read_data;
        S_CALC: begin
          err_q     <= ~legal;
          new_bal_q <= (cmd_q.op == OP_PLACE) ? ram_read_data - cmd_q.bet : settle_bal;
          if (!legal) balance_out <= ram_read_data;
        end
        S_WR_BAL: balance_out <= new_bal_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_blackjack_bet_ledger.sv
// Bench for blackjack_bet_ledger: behavioural game RAM with backdoor preload, directed
// scenarios plus random commands checked against an arithmetic model of the ledger rules.
module tb_blackjack_bet_ledger;
  localparam int CB = 16;
  localparam int SAT = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op, cmd_outcome;
  logic [CB-1:0] cmd_bet;
  logic [3:0]    ram_addr;
  logic [CB-1:0] ram_write_data, ram_read_data, balance_out;
  logic          ram_write_en, done, error;

  logic          bd_en;
  logic [3:0]    bd_addr;
  logic [CB-1:0] bd_data;
  logic [CB-1:0] mem [16];

  int checks = 0;
  int errors = 0;
  int m [4];
  int exp_bo;

  always #5 clk = ~clk;

  blackjack_bet_ledger #(.CURRENCY_BITS(CB), .MAX_BET(500)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bet(cmd_bet), .cmd_outcome(cmd_outcome), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_write_en(ram_write_en), .ram_read_data(ram_read_data),
    .done(done), .error(error), .balance_out(balance_out)
  );

  // Game RAM stand-in: starting balance 1000 on reset, registered read, backdoor has priority.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[0]        <= 16'd1000;
      ram_read_data <= '0;
    end else begin
      if (bd_en) mem[bd_addr] <= bd_data;
      else if (ram_write_en) mem[ram_addr] <= ram_write_data;
      ram_read_data <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m[0] = 1000; m[1] = 0; m[2] = 0; m[3] = 0;
    exp_bo = 0;
  endtask

  task automatic preload(input int a, input int d);
    bd_en = 1'b1; bd_addr = 4'(a); bd_data = CB'(d);
    @(negedge clk);
    bd_en = 1'b0;
    m[a] = d;
  endtask

  // Expected outcome straight from the betting rules.
  task automatic predict(input int op, input int bet, input int oc,
                         output int lat, output int err, output int wes);
    int credit;
    lat = 1; err = 1; wes = 0;
    case (op)
      0: if (bet != 0 && bet <= 500 && bet <= m[0] && m[1] == 0) begin
           m[0] = m[0] - bet; m[1] = bet; exp_bo = m[0];
           lat = 6; err = 0; wes = 2;
         end else begin
           exp_bo = m[0]; lat = 4;
         end
      1: if (m[1] != 0) begin
           credit = (oc == 0) ? 0 : (oc == 1) ? m[1] : (oc == 2) ? 2 * m[1] : (5 * m[1]) / 2;
           m[0] = (m[0] + credit > SAT) ? SAT : m[0] + credit;
           m[1] = 0; exp_bo = m[0];
           lat = 6; err = 0; wes = 2;
         end else begin
           exp_bo = m[0]; lat = 4;
         end
      2: begin m[2] = 0; m[3] = 0; lat = 3; err = 0; wes = 2; end
      default: ;
    endcase
  endtask

  // Entered and left at a negedge with the DUT idle; the exit cycle is the IDLE after DONE,
  // so a following exec() is issued back-to-back.
  task automatic exec(input string tag, input int op, input int bet, input int oc, input bit hold);
    int lat, err, wes, n, we_cnt, rdy_busy;
    bit got;
    predict(op, bet, oc, lat, err, wes);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_bet = CB'(bet); cmd_outcome = 2'(oc);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmd_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    @(posedge clk);
    we_cnt = 0; rdy_busy = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      else begin
        cmd_op = 2'($urandom_range(0, 3)); cmd_bet = CB'($urandom); cmd_outcome = 2'($urandom);
      end
      if (ram_write_en) we_cnt++;
      if (cmd_ready) rdy_busy++;
      if (done) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_error"}, 32'(error), 32'(err));
    chk({tag, "_writes"}, 32'(we_cnt), 32'(wes));
    chk({tag, "_ready_busy"}, 32'(rdy_busy), 32'd0);
    if (op < 2) chk({tag, "_balance_out"}, 32'(balance_out), 32'(exp_bo));
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, error}, 32'd0);
    chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    for (int a = 0; a < 4; a++) chk($sformatf("%s_ram%0d", tag, a), 32'(mem[a]), 32'(m[a]));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_bet = '0; cmd_outcome = '0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_balance", 32'(balance_out), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_we", 32'(ram_write_en), 32'd0);
    chk("rst_wdata", 32'(ram_write_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1 plain bet from the reset balance
    exec("t1_place100", 0, 100, 0, 1'b0);
    // T2 blackjack pays 3:2 floored
    preload(0, 899); preload(1, 101);
    exec("t2_settle_bj", 1, 0, 3, 1'b0);
    // T3 out-of-range bets rejected without touching RAM
    preload(0, 1000); preload(1, 0);
    exec("t3_over_bal", 0, 1001, 0, 1'b0);
    exec("t3_zero", 0, 0, 0, 1'b0);
    exec("t3_over_max", 0, 501, 0, 1'b0);
    exec("t3_at_max", 0, 500, 0, 1'b0);
    // T4 state-dependent rejections and the illegal opcode
    preload(1, 0);
    exec("t4_settle_nobet", 1, 0, 2, 1'b0);
    preload(1, 100);
    exec("t4_place_outstanding", 0, 50, 0, 1'b0);
    exec("t4_op3", 3, 7, 1, 1'b0);
    // T5 saturation on win, then a loss
    preload(0, 65000); preload(1, 1000);
    exec("t5_win_sat", 1, 0, 2, 1'b0);
    preload(1, 1000);
    exec("t5_lose", 1, 0, 0, 1'b0);
    preload(0, 1000); preload(1, 40);
    exec("t5_push", 1, 0, 1, 1'b0);
    // T6 new round with cmd_valid held and inputs scrambled while busy
    preload(2, 3); preload(3, 4);
    exec("t6_newround", 2, 0, 0, 1'b1);
    exec("t6_place_held", 0, 250, 0, 1'b1);

    // T6 reset landing in WR_BET
    preload(0, 1000); preload(1, 0);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_bet = 16'd100; cmd_outcome = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_in_wr_bet", {27'd0, ram_write_en, ram_addr}, {27'd0, 1'b1, 4'd1});
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("t6_rst_done", {30'd0, done, error}, 32'd0);
    chk("t6_rst_we", 32'(ram_write_en), 32'd0);
    chk("t6_rst_bo", 32'(balance_out), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    chk("t6_rst_ram0", 32'(mem[0]), 32'd1000);
    rst = 1'b0;
    @(negedge clk);

    // Random commands, preloads sprinkled in to reach every legality corner
    for (int it = 0; it < 60; it++) begin
      int op, bet, oc, sel;
      if ($urandom_range(0, 1) == 1) preload(0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 700)
                                                                              : $urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) preload(1, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30000));
      if ($urandom_range(0, 4) == 0) begin preload(2, $urandom_range(0, 11)); preload(3, $urandom_range(0, 11)); end
      op  = $urandom_range(0, 3);
      oc  = $urandom_range(0, 3);
      sel = $urandom_range(0, 4);
      bet = (sel == 0) ? 0 : (sel == 1) ? 500 : (sel == 2) ? 501 :
            (sel == 3) ? m[0] : $urandom_range(1, 600);
      exec($sformatf("rnd%0d", it), op, bet & 16'hFFFF, oc, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
